// File: rtl/seq_chunk_adder_pkg.sv
// Shared definitions for the chunked adder: FSM state encoding and sizing helpers.
package seq_chunk_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of CHUNK-wide slices that make up one WIDTH-wide operand.
    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk index counter width; never narrower than one bit so that
    // the single-slice configuration still has a legal counter.
    function automatic int calc_cnt_w(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

endpackage

// File: rtl/seq_chunk_adder_rca.sv
// Combinational CHUNK-bit ripple-carry chain of full-adder cells.
// c_msb is the carry entering the top bit, used for signed overflow.
module chunk_rca #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    // Ripple the carry through one full-adder cell per bit.
    always_comb begin
        logic carry;
        sum   = '0;
        c_msb = 1'b0;
        carry = cin;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: one shared CHUNK-bit ripple slice walks the
// operands from LSB to MSB, carrying between slices in a register.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. in_ready is high only in IDLE (and never during reset);
// out_valid is high only in DONE, and out_sum/out_cout/out_ovf hold steady
// until the consumer takes them with out_ready.
module seq_chunk_adder
    import seq_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NCH = calc_nch(WIDTH, CHUNK);
    localparam int CW  = calc_cnt_w(NCH);
    localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    idx_q;
    logic             carry_q;
    logic             cout_q;
    logic             ovf_q;
    logic             accept;
    logic             step;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_c_msb;

    assign slice_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign slice_b = b_q[int'(idx_q) * CHUNK +: CHUNK];

    chunk_rca #(.CHUNK(CHUNK)) u_rca (
        .a     (slice_a),
        .b     (slice_b),
        .cin   (carry_q),
        .sum   (slice_sum),
        .cout  (slice_cout),
        .c_msb (slice_c_msb)
    );

    assign out_sum  = sum_q;
    assign out_cout = cout_q;
    assign out_ovf  = ovf_q;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode, handshake outputs and datapath strobes.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~reset;
                accept   = in_valid & ~reset;
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, per-slice result write-back, carry chaining and flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            // Subtraction is A + ~B + ~borrow, so fold the inversion in here.
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub ? ~in_cin : in_cin;
            idx_q   <= '0;
        end else if (step) begin
            sum_q[int'(idx_q) * CHUNK +: CHUNK] <= slice_sum;
            carry_q <= slice_cout;
            if (idx_q == LAST_IDX) begin
                cout_q <= slice_cout;
                ovf_q  <= slice_c_msb ^ slice_cout;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule
